// File: rtl/sram_like_responder.sv
// SRAM-like slave: byte-strobed word memory with in-order, fixed-latency responses
// and up to DEPTH outstanding transactions tracked in a small circular queue.
module sram_like_responder #(
    parameter int AW      = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam logic [3:0] AGE_INIT  = 4'(LATENCY - 1);
    localparam logic [2:0] DEPTH_C   = 3'(DEPTH);
    localparam logic [1:0] LAST_SLOT = 2'(DEPTH - 1);

    logic [31:0]   mem    [0:(1<<AW)-1];
    logic [31:0]   q_data [0:3];
    logic [3:0]    q_wr;
    logic [3:0]    q_age  [0:3];
    logic [1:0]    head;
    logic [1:0]    tail;
    logic [2:0]    count;
    logic [AW-1:0] widx;
    logic          accept;
    logic          retire;
    logic          unused_addr_bits;

    assign widx             = addr[AW+1:2];
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    // A slot retiring this cycle is still counted, so it cannot be reused until next cycle.
    assign addr_ok = resetn & req & (count < DEPTH_C);
    assign accept  = addr_ok;
    assign data_ok = (count != 3'd0) && (q_age[head] == 4'd0);
    assign retire  = data_ok;
    assign rdata   = (data_ok && !q_wr[head]) ? q_data[head] : 32'h0;

    function automatic logic [1:0] next_slot(input logic [1:0] p);
        return (p == LAST_SLOT) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= 2'd0;
            tail  <= 2'd0;
            count <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                q_age[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (q_age[i] != 4'd0) begin
                    q_age[i] <= q_age[i] - 4'd1;
                end
            end
            if (accept) begin
                q_age[tail] <= AGE_INIT;
                tail        <= next_slot(tail);
            end
            if (retire) begin
                head <= next_slot(head);
            end
            case ({accept, retire})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Read data is snapshotted at accept so later writes never disturb a queued response.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_wr[tail] <= wr;
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) begin
                        mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                q_data[tail] <= mem[widx];
            end
        end
    end
endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed vector table followed by randomized traffic
// checked against a transaction-level model (memory array + queue of due times).
module tb_sram_like_responder;
    localparam int AW      = 10;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 2;

    logic        clk = 1'b1;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    sram_like_responder #(.AW(AW), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    typedef struct {
        logic        rst;
        logic        req;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_ao;
        logic        e_dok;
        logic [31:0] e_rd;
    } vec_t;

    typedef struct {
        logic        is_wr;
        logic [31:0] data;
        int          due;
    } txn_t;

    vec_t        tab[$];
    txn_t        mq[$];
    logic [31:0] mmem [0:(1<<AW)-1];
    int          edge_n = 0;
    int          last_due = 0;
    int          total = 0;
    int          bad = 0;

    function automatic vec_t mk(input logic rst, input logic rq, input logic w,
                                input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                                input logic ao, input logic dok, input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.req = rq; v.wr = w; v.strb = s; v.addr = a; v.wdata = d;
        v.e_ao = ao; v.e_dok = dok; v.e_rd = rd;
        return v;
    endfunction

    task automatic check1(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, got, exp);
        end
    endtask

    // One clock cycle: drive, sample at negedge, then advance the model at the posedge.
    task automatic run_cycle(input vec_t v, input bit use_tab, input int row, output bit acc);
        logic        m_ao;
        logic        m_dok;
        logic [31:0] m_rd;
        txn_t        t;
        int          idx;
        resetn = !v.rst; req = v.req; wr = v.wr; wstrb = v.strb; addr = v.addr; wdata = v.wdata;
        @(negedge clk);
        m_ao  = !v.rst && v.req && (mq.size() < DEPTH);
        m_dok = !v.rst && (mq.size() > 0) && (mq[0].due <= edge_n);
        m_rd  = (m_dok && !mq[0].is_wr) ? mq[0].data : 32'h0;
        if (use_tab) begin
            check1("addr_ok", row, {31'h0, addr_ok}, {31'h0, v.e_ao});
            check1("data_ok", row, {31'h0, data_ok}, {31'h0, v.e_dok});
            check1("rdata", row, rdata, v.e_rd);
        end else begin
            check1("rnd_addr_ok", row, {31'h0, addr_ok}, {31'h0, m_ao});
            check1("rnd_data_ok", row, {31'h0, data_ok}, {31'h0, m_dok});
            check1("rnd_rdata", row, rdata, m_rd);
        end
        acc = m_ao;
        @(posedge clk);
        if (v.rst) begin
            mq.delete();
            last_due = 0;
        end else begin
            if (m_dok) void'(mq.pop_front());
            if (m_ao) begin
                idx     = int'(v.addr[AW+1:2]);
                t.is_wr = v.wr;
                t.data  = mmem[idx];
                t.due   = (edge_n + LATENCY > last_due + 1) ? edge_n + LATENCY : last_due + 1;
                last_due = t.due;
                mq.push_back(t);
                if (v.wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (v.strb[b]) mmem[idx][8*b +: 8] = v.wdata[8*b +: 8];
                    end
                end
            end
        end
        edge_n++;
        #1;
    endtask

    initial begin
        bit          acc;
        bit          hold;
        int          tries;
        vec_t        cur;
        logic [31:0] r;

        // reset, then single write/read
        tab.push_back(mk(1, 1, 1, 4'hF, 32'h40, 32'hDEADBEEF, 0, 0, 32'h0));
        tab.push_back(mk(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        tab.push_back(mk(0, 1, 1, 4'hF, 32'h40, 32'hDEADBEEF, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h40, 32'h0, 1, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hDEADBEEF));
        // byte strobes with a stall on the third request
        tab.push_back(mk(0, 1, 1, 4'hF, 32'h80, 32'h11223344, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 1, 4'h5, 32'h80, 32'hAABBCCDD, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h80, 32'h0, 0, 1, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h80, 32'h0, 1, 1, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h11BB33DD));
        // backpressure: three reads held high
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h40, 32'h0, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h80, 32'h0, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h40, 32'h0, 0, 1, 32'hDEADBEEF));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h40, 32'h0, 1, 1, 32'h11BB33DD));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hDEADBEEF));
        // read-before-write ordering at 0x100
        tab.push_back(mk(0, 1, 1, 4'hF, 32'h100, 32'h0, 1, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h100, 32'h0, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 1, 4'hF, 32'h100, 32'h5, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h100, 32'h0, 0, 1, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h100, 32'h0, 1, 1, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h5));
        // reset with two reads in flight
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h40, 32'h0, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h80, 32'h0, 1, 0, 32'h0));
        tab.push_back(mk(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h40, 32'h0, 1, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hDEADBEEF));
        // address aliasing
        tab.push_back(mk(0, 1, 1, 4'hF, 32'h1000_0004, 32'h1, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0004, 32'h0, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0007, 32'h0, 0, 1, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0007, 32'h0, 1, 1, 32'h1));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h1));
        // zero-strobe write leaves memory unchanged
        tab.push_back(mk(0, 1, 1, 4'h0, 32'h40, 32'hFFFFFFFF, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 0, 4'h0, 32'h40, 32'h0, 1, 0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hDEADBEEF));

        foreach (tab[i]) run_cycle(tab[i], 1'b1, i, acc);

        // preload the random working set so every read has a defined value
        for (int k = 0; k < 16; k++) begin
            cur = mk(0, 1, 1, 4'hF, 32'h200 + 32'(4 * k), $urandom, 0, 0, 32'h0);
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 20) begin
                run_cycle(cur, 1'b0, 1000 + k, acc);
                tries++;
            end
            if (!acc) begin
                bad++;
                total++;
                $display("FAIL preload_accept row=%0d got=timeout want=accept", k);
            end
        end

        hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                r        = $urandom;
                cur.rst  = ($urandom_range(0, 79) == 0);
                cur.req  = ($urandom_range(0, 9) < 6);
                cur.wr   = $urandom_range(0, 1) == 1;
                cur.strb = 4'($urandom_range(0, 15));
                cur.addr = (r & 32'hFFFF_F000) | 32'h200 | 32'(4 * $urandom_range(0, 15))
                           | 32'($urandom_range(0, 3));
                cur.wdata = $urandom;
            end
            run_cycle(cur, 1'b0, 2000 + n, acc);
            hold = cur.req && !acc && !cur.rst;
        end
        cur = mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        for (int n = 0; n < 8; n++) run_cycle(cur, 1'b0, 3000 + n, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
